msx_config_parser: RTL and testbench

MSX_CONFIG_PARSER -- requirements
Module: msx_config_parser

---
 rtl/msx_config_parser_pkg.sv | 69 ++++++
 rtl/msx_config_parser.sv | 151 +++++++++++++++
 tb/tb_msx_config_parser.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msx_config_parser_pkg.sv
// Shared MSX type package: configuration record field encodings, block-table
// entry layout, BIOS configuration word and the parser state encoding.
package MSX;

    typedef enum logic [3:0] {
        CONFIG_NONE          = 4'd0,
        CONFIG_FDC           = 4'd1,
        CONFIG_SLOT_A        = 4'd2,
        CONFIG_SLOT_B        = 4'd3,
        CONFIG_SLOT_INTERNAL = 4'd4,
        CONFIG_KBD_LAYOUT    = 4'd5,
        CONFIG_CONFIG        = 4'd6
    } config_typ_t;

    typedef enum logic [7:0] {
        ROM_NONE = 8'd0,
        ROM_ROM  = 8'd1,
        ROM_RAM  = 8'd2,
        ROM_FDC  = 8'd3
    } data_ID_t;

    typedef enum logic [3:0] {
        DEVICE_NONE = 4'd0,
        DEVICE_FDC  = 4'd1,
        DEVICE_SCC  = 4'd2,
        DEVICE_OPL  = 4'd3
    } device_typ_t;

    typedef enum logic [4:0] {
        MAPPER_UNUSED     = 5'd0,
        MAPPER_OFFSET     = 5'd1,
        MAPPER_RAM        = 5'd2,
        MAPPER_ASCII8     = 5'd3,
        MAPPER_ASCII16    = 5'd4,
        MAPPER_KONAMI     = 5'd5,
        MAPPER_KONAMI_SCC = 5'd6
    } mapper_typ_t;

    typedef struct packed {
        logic [3:0]  ref_ram;
        logic [1:0]  offset_ram;
        mapper_typ_t mapper;
        device_typ_t device;
        logic        cart_num;
    } block_t;

    typedef struct packed {
        logic [3:0] slot_expander_en;
        logic       MSX_typ;
        logic [7:0] ram_size;
    } bios_config_t;

    // Two-bit page mode field encodings (byte 6 of a record).
    localparam logic [1:0] PAGE_UNMAPPED = 2'b00;
    localparam logic [1:0] PAGE_MIRROR   = 2'b01;
    localparam logic [1:0] PAGE_MAPPED   = 2'b10;
    localparam logic [1:0] PAGE_RESERVED = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RECV,
        ST_DECODE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } parser_state_t;

endpackage

// File: rtl/msx_config_parser.sv
// MSX configuration stream parser.
// Clears the 64-entry block table, then consumes 12-byte config records and
// turns each slot/FDC record into up to four block-table writes, while
// accumulating the BIOS configuration word.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle pulse, (re)starts a parse from CLEAR
//   cfg_valid/ready   byte handshake, cfg_data is the record byte stream
//   blk_we/addr/data  block-table write port, addr = {slot, subslot, page}
//   bios_cfg          accumulated BIOS configuration
//   done, error       parse status, held until the next start
module msx_config_parser
    import MSX::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         cfg_valid,
    input  logic [7:0]   cfg_data,
    output logic         cfg_ready,
    output logic         blk_we,
    output logic [5:0]   blk_addr,
    output block_t       blk_data,
    output bios_config_t bios_cfg,
    output logic         done,
    output logic         error
);

    parser_state_t state, next_state;
    logic [5:0] cnt;        // CLEAR address, then WRITE page in [1:0]
    logic [3:0] byte_idx;
    logic [3:0] ref_cnt;
    logic [7:0] rec [8];    // bytes 8..11 are never stored

    logic [3:0] typ;
    logic [1:0] slot, subslot, page, page_mode, page_offset;
    logic       table_typ, bad_typ, reserved_mode, new_ref, ref_ovf, accept;
    logic       unused_bits;

    function automatic logic [7:0] sat_add_ram(input logic [7:0] acc, input logic [15:0] blocks);
        logic [16:0] sum;
        sum = {9'd0, acc} + {1'b0, blocks};
        return (sum > 17'd255) ? 8'hFF : sum[7:0];
    endfunction

    assign typ         = rec[0][7:4];
    assign slot        = rec[0][3:2];
    assign subslot     = rec[0][1:0];
    assign page        = cnt[1:0];
    assign page_mode   = rec[6][{page, 1'b0} +: 2];
    assign page_offset = rec[7][{page, 1'b0} +: 2];
    assign unused_bits = ^{rec[4][7:4], rec[5][7:5]};

    assign table_typ = (typ == CONFIG_FDC) || (typ == CONFIG_SLOT_A) ||
                       (typ == CONFIG_SLOT_B) || (typ == CONFIG_SLOT_INTERNAL);
    assign bad_typ   = (typ == CONFIG_NONE) || (typ > CONFIG_CONFIG);
    assign reserved_mode = (rec[6][1:0] == PAGE_RESERVED) || (rec[6][3:2] == PAGE_RESERVED) ||
                           (rec[6][5:4] == PAGE_RESERVED) || (rec[6][7:6] == PAGE_RESERVED);
    // The reference counter only tracks table records; other record types
    // carry unrelated data in byte 1.
    assign new_ref = (rec[1] != ROM_NONE);
    assign ref_ovf = new_ref && (ref_cnt == 4'hF);
    assign accept  = (state == ST_DECODE) && (next_state == ST_WRITE);

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        blk_we     = 1'b0;
        blk_addr   = '0;
        blk_data   = '0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_CLEAR: begin
                blk_we   = 1'b1;
                blk_addr = cnt;
                if (cnt == 6'd63) next_state = ST_RECV;
            end
            ST_RECV: begin
                cfg_ready = 1'b1;
                if (cfg_valid && byte_idx == 4'd11) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (bad_typ)                      next_state = ST_ERROR;
                else if (typ == CONFIG_CONFIG)    next_state = ST_DONE;
                else if (!table_typ)              next_state = ST_RECV;
                else if (reserved_mode || ref_ovf) next_state = ST_ERROR;
                else                              next_state = ST_WRITE;
            end
            ST_WRITE: begin
                blk_we              = (page_mode == PAGE_MAPPED) || (page_mode == PAGE_MIRROR);
                blk_addr            = {slot, subslot, page};
                blk_data.ref_ram    = ref_cnt;
                blk_data.offset_ram = page_offset;
                blk_data.mapper     = mapper_typ_t'(rec[5][4:0]);
                blk_data.device     = device_typ_t'(rec[4][3:0]);
                blk_data.cart_num   = (typ == CONFIG_SLOT_B);
                if (page == 2'd3) next_state = ST_RECV;
            end
            ST_DONE:  done  = 1'b1;
            ST_ERROR: error = 1'b1;
            default:  next_state = ST_IDLE;
        endcase
        if (start) next_state = ST_CLEAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            byte_idx <= '0;
            ref_cnt  <= '0;
            bios_cfg <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                cnt      <= '0;
                byte_idx <= '0;
                ref_cnt  <= '0;
                bios_cfg <= '0;
            end else begin
                case (state)
                    ST_CLEAR: cnt <= cnt + 6'd1;
                    ST_RECV: begin
                        if (cfg_valid) byte_idx <= (byte_idx == 4'd11) ? 4'd0 : byte_idx + 4'd1;
                    end
                    ST_DECODE: begin
                        if (accept) begin
                            cnt <= '0;
                            if (new_ref) ref_cnt <= ref_cnt + 4'd1;
                            if (subslot != 2'd0) bios_cfg.slot_expander_en[slot] <= 1'b1;
                            if (rec[1] == ROM_RAM)
                                bios_cfg.ram_size <= sat_add_ram(bios_cfg.ram_size, {rec[2], rec[3]});
                        end
                        if (next_state == ST_DONE) bios_cfg.MSX_typ <= rec[1][0];
                    end
                    ST_WRITE: cnt <= cnt + 6'd1;
                    default: ;
                endcase
            end
        end
    end

    // Record bytes are payload only; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (state == ST_RECV && cfg_valid && !byte_idx[3])
            rec[byte_idx[2:0]] <= cfg_data;
    end

endmodule

// File: tb/tb_msx_config_parser.sv
module tb_msx_config_parser;
    import MSX::*;

    typedef logic [95:0] rec_t;  // byte 0 in bits [95:88]

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         cfg_valid;
    logic [7:0]   cfg_data;
    logic         cfg_ready;
    logic         blk_we;
    logic [5:0]   blk_addr;
    block_t       blk_data;
    bios_config_t bios_cfg;
    logic         done;
    logic         error;

    msx_config_parser dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .blk_we(blk_we), .blk_addr(blk_addr), .blk_data(blk_data),
        .bios_cfg(bios_cfg), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed table writes, one entry per cycle with blk_we high.
    logic [5:0] wr_a [$];
    block_t     wr_d [$];
    always @(negedge clk) begin
        if (blk_we) begin
            wr_a.push_back(blk_addr);
            wr_d.push_back(blk_data);
        end
    end

    // Reference model state
    rec_t         recs [$];
    logic [5:0]   exp_wa [$];
    block_t       exp_wd [$];
    bios_config_t exp_bios;
    int           exp_end;   // 1 = done, 2 = error
    int           n_used;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] cnt,
                                input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                                input logic [7:0] b7);
        return {b0, b1, cnt, b4, b5, b6, b7, 32'h0};
    endfunction

    function automatic rec_t rnd_rec();
        logic [7:0] b0, b6;
        logic [3:0] t;
        t = 4'($urandom_range(1, 5));
        if ($urandom_range(0, 11) == 0) t = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(7, 15));
        b0 = {t, 4'($urandom)};
        for (int p = 0; p < 4; p++) b6[2*p +: 2] = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) b6[2*$urandom_range(0, 3) +: 2] = 2'b11;
        return {b0, 8'($urandom_range(0, 3)), 16'($urandom), 8'($urandom), 8'($urandom), b6,
                8'($urandom), 32'($urandom)};
    endfunction

    // Walks the record list applying the parsing rules directly.
    task automatic run_model();
        logic [7:0] b [12];
        int ref_m, sum;
        logic [3:0] t;
        logic [1:0] mode;
        bit bad;
        block_t e;
        ref_m = 0; exp_bios = '0; exp_end = 0; n_used = 0;
        exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < recs.size() && exp_end == 0; i++) begin
            n_used++;
            for (int k = 0; k < 12; k++) b[k] = recs[i][95-8*k -: 8];
            t = b[0][7:4];
            if (t == 4'd0 || t > 4'd6) exp_end = 2;
            else if (t == 4'd6) begin exp_bios.MSX_typ = b[1][0]; exp_end = 1; end
            else if (t != 4'd5) begin
                bad = 0;
                for (int p = 0; p < 4; p++) if (b[6][2*p +: 2] == 2'b11) bad = 1;
                if (b[1] != 8'd0 && ref_m == 15) bad = 1;
                if (bad) exp_end = 2;
                else begin
                    if (b[1] != 8'd0) ref_m++;
                    if (b[0][1:0] != 2'd0) exp_bios.slot_expander_en[b[0][3:2]] = 1'b1;
                    if (b[1] == 8'd2) begin
                        sum = int'(exp_bios.ram_size) + int'({b[2], b[3]});
                        exp_bios.ram_size = (sum > 255) ? 8'hFF : 8'(sum);
                    end
                    for (int p = 0; p < 4; p++) begin
                        mode = b[6][2*p +: 2];
                        if (mode == 2'b01 || mode == 2'b10) begin
                            e.ref_ram    = 4'(ref_m);
                            e.offset_ram = b[7][2*p +: 2];
                            e.mapper     = mapper_typ_t'(b[5][4:0]);
                            e.device     = device_typ_t'(b[4][3:0]);
                            e.cart_num   = (t == 4'd3);
                            exp_wa.push_back({b[0][3:0], 2'(p)});
                            exp_wd.push_back(e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] bv, output bit ok);
        int t = 0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); cfg_valid = 1'b0; cfg_data = 8'($urandom);
        end
        @(negedge clk); cfg_valid = 1'b1; cfg_data = bv;
        while (!cfg_ready && t < 3000) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        ok = (t < 3000);
    endtask

    task automatic run_parse(input string tag);
        bit ok, all_ok;
        int t, bad;
        run_model();
        wr_a.delete(); wr_d.delete();
        pulse_start();
        check({tag, "_flags_drop"}, {30'h0, done, error}, 32'h0);
        all_ok = 1;
        for (int i = 0; i < n_used; i++)
            for (int k = 0; k < 12; k++) begin
                send_byte(recs[i][95-8*k -: 8], ok);
                if (!ok) all_ok = 0;
            end
        check({tag, "_handshake"}, {31'h0, all_ok}, 32'h1);
        t = 0;
        while (!(done || error) && t < 3000) begin @(negedge clk); t++; end
        check({tag, "_status"}, {30'h0, done, error}, (exp_end == 1) ? 32'h2 : 32'h1);
        repeat (4) @(negedge clk);
        check({tag, "_ready_low"}, {31'h0, cfg_ready}, 32'h0);
        check({tag, "_nwrites"}, wr_a.size(), 64 + exp_wa.size());
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (i >= wr_a.size() || wr_a[i] != 6'(i) || wr_d[i] != '0) bad++;
        check({tag, "_clear"}, bad, 0);
        for (int i = 0; i < exp_wa.size(); i++) begin
            check($sformatf("%s_wa%0d", tag, i), {26'h0, wr_a[64+i]}, {26'h0, exp_wa[i]});
            check($sformatf("%s_wd%0d", tag, i), {16'h0, wr_d[64+i]}, {16'h0, exp_wd[i]});
        end
        check({tag, "_bios"}, {19'h0, bios_cfg}, {19'h0, exp_bios});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, cfg_ready}, 32'h0);
        check("rst_we", {31'h0, blk_we}, 32'h0);
        check("rst_addr", {26'h0, blk_addr}, 32'h0);
        check("rst_data", {16'h0, blk_data}, 32'h0);
        check("rst_bios", {19'h0, bios_cfg}, 32'h0);
        check("rst_flags", {30'h0, done, error}, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_write", wr_a.size(), 0);

        // RAM record over all four pages, then the machine-config record.
        recs.delete();
        recs.push_back(mk(8'h4C, 8'h02, 16'h0004, 8'h00, 8'h02, 8'hAA, 8'hE4));
        recs.push_back(mk(8'h60, 8'h01, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        run_parse("r033");
        check("r033_a0", {26'h0, wr_a[64]}, 32'h30);
        check("r033_a3", {26'h0, wr_a[67]}, 32'h33);
        check("r033_off2", {30'h0, wr_d[66].offset_ram}, 32'h2);
        check("r033_map", {27'h0, wr_d[65].mapper}, 32'h2);
        check("r033_ref", {28'h0, wr_d[67].ref_ram}, 32'h1);
        check("r033_ram", {24'h0, bios_cfg.ram_size}, 32'h4);
        check("r033_typ", {31'h0, bios_cfg.MSX_typ}, 32'h1);
        check("r033_done", {31'h0, done}, 32'h1);

        // FDC in an expanded slot, single mapped page.
        recs.delete();
        recs.push_back(mk(8'h4F, 8'h03, 16'h0001, 8'h01, 8'h00, 8'h08, 8'h00));
        recs.push_back(mk(8'h60, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        run_parse("r034");
        check("r034_addr", {26'h0, wr_a[64]}, 32'h3D);
        check("r034_dev", {28'h0, wr_d[64].device}, 32'h1);
        check("r034_exp", {28'h0, bios_cfg.slot_expander_en}, 32'h8);

        // ROM followed by a mirror that reuses the current reference.
        recs.delete();
        recs.push_back(mk(8'h4C, 8'h01, 16'h0002, 8'h00, 8'h01, 8'h02, 8'h00));
        recs.push_back(mk(8'h4C, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h04, 8'h00));
        recs.push_back(mk(8'h60, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        run_parse("r035");
        check("r035_addr", {26'h0, wr_a[65]}, 32'h31);
        check("r035_ref", {28'h0, wr_d[65].ref_ram}, 32'h1);

        // Invalid header, then a restart that reparses cleanly.
        recs.delete();
        recs.push_back(mk(8'h70, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        run_parse("r036");
        check("r036_err", {31'h0, error}, 32'h1);
        recs.delete();
        recs.push_back(mk(8'h4C, 8'h02, 16'h0004, 8'h00, 8'h02, 8'hAA, 8'hE4));
        recs.push_back(mk(8'h60, 8'h01, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00));
        run_parse("r036b");

        // Reset in the middle of a record.
        pulse_start();
        for (int k = 0; k < 5; k++) send_byte(8'h4C, ok);
        wr_a.delete(); wr_d.delete();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check("r037_ready", {31'h0, cfg_ready}, 32'h0);
        check("r037_we", {31'h0, blk_we}, 32'h0);
        check("r037_addr", {26'h0, blk_addr}, 32'h0);
        check("r037_data", {16'h0, blk_data}, 32'h0);
        check("r037_bios", {19'h0, bios_cfg}, 32'h0);
        check("r037_flags", {30'h0, done, error}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("r037_nowrite", wr_a.size(), 0);
        check("r037_idle", {31'h0, cfg_ready}, 32'h0);

        // Reference counter overflow on the 16th new reference.
        recs.delete();
        for (int i = 0; i < 17; i++) begin
            logic [7:0] m;
            for (int p = 0; p < 4; p++) m[2*p +: 2] = 2'($urandom_range(0, 2));
            recs.push_back(mk({4'd2, 4'(i)}, 8'h01, 16'h0001, 8'h00, 8'h03, m, 8'($urandom)));
        end
        run_parse("r038");
        check("r038_used", n_used, 16);
        check("r038_err", {31'h0, error}, 32'h1);

        // Randomised record streams.
        for (int it = 0; it < 6; it++) begin
            recs.delete();
            repeat ($urandom_range(2, 6)) recs.push_back(rnd_rec());
            recs.push_back(mk(8'h60, 8'($urandom_range(0, 1)), 16'h0, 8'h0, 8'h0, 8'h0, 8'h0));
            run_parse($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
